// File: rtl/memory_port_arbiter.sv
// Two-requester memory port arbiter: grants one read/write at a time to a single
// memory port, alternating on ties, with a sticky timeout abort.
module memory_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 20,
    parameter int NUM_BYTES      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    r0_read,
    input  logic                    r0_write,
    input  logic [NUM_BYTES-1:0]    r0_byte_en,
    input  logic [ADDRESS_BITS-1:0] r0_address,
    input  logic [DATA_WIDTH-1:0]   r0_data,
    output logic                    r0_ready,
    output logic                    r0_valid,
    output logic [DATA_WIDTH-1:0]   r0_rdata,
    input  logic                    r1_read,
    input  logic                    r1_write,
    input  logic [NUM_BYTES-1:0]    r1_byte_en,
    input  logic [ADDRESS_BITS-1:0] r1_address,
    input  logic [DATA_WIDTH-1:0]   r1_data,
    output logic                    r1_ready,
    output logic                    r1_valid,
    output logic [DATA_WIDTH-1:0]   r1_rdata,
    output logic                    memory_read,
    output logic                    memory_write,
    output logic [NUM_BYTES-1:0]    memory_byte_en,
    output logic [ADDRESS_BITS-1:0] memory_address,
    output logic [DATA_WIDTH-1:0]   memory_data,
    input  logic                    memory_ready,
    input  logic                    memory_valid,
    input  logic [DATA_WIDTH-1:0]   memory_rdata,
    output logic                    timeout_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t                    state_q, state_d;
    logic                      last_grant_q, last_grant_d;
    logic                      grant_q, grant_d;
    logic                      cmd_write_q, cmd_write_d;
    logic [NUM_BYTES-1:0]      byte_en_q, byte_en_d;
    logic [ADDRESS_BITS-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic                      timeout_error_q, timeout_error_d;
    logic                      r0_valid_q, r0_valid_d;
    logic                      r1_valid_q, r1_valid_d;
    logic [DATA_WIDTH-1:0]     r0_rdata_q, r0_rdata_d;
    logic [DATA_WIDTH-1:0]     r1_rdata_q, r1_rdata_d;

    logic                      r0_pending;
    logic                      r1_pending;
    logic                      grant_now;
    logic                      grant_sel;
    logic                      timed_out;
    logic                      finish;
    logic [DATA_WIDTH-1:0]     finish_data;

    // grant_sel=1 selects requester 1; on a tie the requester not granted last wins
    always_comb begin
        r0_pending = r0_read | r0_write;
        r1_pending = r1_read | r1_write;
        grant_now  = (state_q == IDLE) && (r0_pending || r1_pending);
        grant_sel  = r1_pending;
        if (r0_pending && r1_pending) begin
            grant_sel = ~last_grant_q;
        end
    end

    assign r0_ready = grant_now & ~grant_sel;
    assign r1_ready = grant_now & grant_sel;

    // Abort decided one cycle early so the registered valid lands TIMEOUT_CYCLES after grant
    assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES - 2));

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_d         = grant_q;
        cmd_write_d     = cmd_write_q;
        byte_en_d       = byte_en_q;
        address_d       = address_q;
        data_d          = data_q;
        timer_d         = timer_q;
        timeout_error_d = timeout_error_q;
        r0_valid_d      = 1'b0;
        r1_valid_d      = 1'b0;
        r0_rdata_d      = r0_rdata_q;
        r1_rdata_d      = r1_rdata_q;
        finish          = 1'b0;
        finish_data     = '0;

        case (state_q)
            IDLE: begin
                if (grant_now) begin
                    grant_d     = grant_sel;
                    cmd_write_d = grant_sel ? r1_write   : r0_write;
                    byte_en_d   = grant_sel ? r1_byte_en : r0_byte_en;
                    address_d   = grant_sel ? r1_address : r0_address;
                    data_d      = grant_sel ? r1_data    : r0_data;
                    timer_d     = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = timer_q + TW'(1);
                if (timed_out) begin
                    finish          = 1'b1;
                    finish_data     = '1;
                    timeout_error_d = 1'b1;
                end else if (memory_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                // A completion arriving on the timeout cycle still counts as a completion
                if (memory_valid) begin
                    finish      = 1'b1;
                    finish_data = cmd_write_q ? '0 : memory_rdata;
                end else if (timed_out) begin
                    finish          = 1'b1;
                    finish_data     = '1;
                    timeout_error_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            if (grant_q) begin
                r1_valid_d = 1'b1;
                r1_rdata_d = finish_data;
            end else begin
                r0_valid_d = 1'b1;
                r0_rdata_d = finish_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            last_grant_q    <= 1'b1;
            grant_q         <= 1'b0;
            cmd_write_q     <= 1'b0;
            byte_en_q       <= '0;
            address_q       <= '0;
            data_q          <= '0;
            timer_q         <= '0;
            timeout_error_q <= 1'b0;
            r0_valid_q      <= 1'b0;
            r1_valid_q      <= 1'b0;
            r0_rdata_q      <= '0;
            r1_rdata_q      <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            grant_q         <= grant_d;
            cmd_write_q     <= cmd_write_d;
            byte_en_q       <= byte_en_d;
            address_q       <= address_d;
            data_q          <= data_d;
            timer_q         <= timer_d;
            timeout_error_q <= timeout_error_d;
            r0_valid_q      <= r0_valid_d;
            r1_valid_q      <= r1_valid_d;
            r0_rdata_q      <= r0_rdata_d;
            r1_rdata_q      <= r1_rdata_d;
        end
    end

    // The memory command is only driven while issuing
    always_comb begin
        memory_read    = 1'b0;
        memory_write   = 1'b0;
        memory_byte_en = '0;
        memory_address = '0;
        memory_data    = '0;
        if (state_q == ISSUE) begin
            memory_read    = ~cmd_write_q;
            memory_write   = cmd_write_q;
            memory_byte_en = byte_en_q;
            memory_address = address_q;
            memory_data    = data_q;
        end
    end

    assign r0_valid      = r0_valid_q;
    assign r1_valid      = r1_valid_q;
    assign r0_rdata      = r0_rdata_q;
    assign r1_rdata      = r1_rdata_q;
    assign timeout_error = timeout_error_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: a per-cycle vector table for the
// basic/tie/write-wins flows, then hand sequences for backpressure, timeout and reset.
module tb_memory_port_arbiter;

    localparam logic [19:0] R0_ADDR = 20'h00010;
    localparam logic [19:0] R1_ADDR = 20'h00020;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        r0_read, r0_write, r1_read, r1_write;
    logic [3:0]  r0_byte_en, r1_byte_en;
    logic [19:0] r0_address, r1_address;
    logic [31:0] r0_data, r1_data;
    logic        r0_ready, r0_valid, r1_ready, r1_valid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        memory_read, memory_write;
    logic [3:0]  memory_byte_en;
    logic [19:0] memory_address;
    logic [31:0] memory_data;
    logic        memory_ready, memory_valid;
    logic [31:0] memory_rdata;
    logic        timeout_error;

    int checkCount = 0;
    int passCount  = 0;

    memory_port_arbiter #(
        .DATA_WIDTH(32), .ADDRESS_BITS(20), .NUM_BYTES(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset),
        .r0_read(r0_read), .r0_write(r0_write), .r0_byte_en(r0_byte_en),
        .r0_address(r0_address), .r0_data(r0_data),
        .r0_ready(r0_ready), .r0_valid(r0_valid), .r0_rdata(r0_rdata),
        .r1_read(r1_read), .r1_write(r1_write), .r1_byte_en(r1_byte_en),
        .r1_address(r1_address), .r1_data(r1_data),
        .r1_ready(r1_ready), .r1_valid(r1_valid), .r1_rdata(r1_rdata),
        .memory_read(memory_read), .memory_write(memory_write),
        .memory_byte_en(memory_byte_en), .memory_address(memory_address),
        .memory_data(memory_data), .memory_ready(memory_ready),
        .memory_valid(memory_valid), .memory_rdata(memory_rdata),
        .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        r0r, r0w, r1r, r1w, mr, mv;
        logic [31:0] mrdata;
        logic        eR0rdy, eR1rdy, eR0v, eR1v, eMrd, eMwr;
        logic [19:0] eAddr;
        logic [31:0] eRd0, eRd1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(
        input logic r0r, input logic r0w, input logic r1r, input logic r1w,
        input logic mr, input logic mv, input logic [31:0] mrdata,
        input logic eR0rdy, input logic eR1rdy, input logic eR0v, input logic eR1v,
        input logic eMrd, input logic eMwr, input logic [19:0] eAddr,
        input logic [31:0] eRd0, input logic [31:0] eRd1);
        vec_t v;
        v.r0r = r0r; v.r0w = r0w; v.r1r = r1r; v.r1w = r1w;
        v.mr = mr; v.mv = mv; v.mrdata = mrdata;
        v.eR0rdy = eR0rdy; v.eR1rdy = eR1rdy; v.eR0v = eR0v; v.eR1v = eR1v;
        v.eMrd = eMrd; v.eMwr = eMwr; v.eAddr = eAddr;
        v.eRd0 = eRd0; v.eRd1 = eRd1;
        return v;
    endfunction

    task automatic setIn(input logic r0r, input logic r0w, input logic r1r, input logic r1w,
                         input logic mr, input logic mv, input logic [31:0] mrdata);
        r0_read = r0r; r0_write = r0w; r1_read = r1r; r1_write = r1w;
        memory_ready = mr; memory_valid = mv; memory_rdata = mrdata;
    endtask

    task automatic applyStimulus(input vec_t v);
        setIn(v.r0r, v.r0w, v.r1r, v.r1w, v.mr, v.mv, v.mrdata);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic nextCycle;
        @(posedge clock);
        #1;
    endtask

    task automatic sampleEdge;
        @(negedge clock);
    endtask

    initial begin
        r0_byte_en = 4'hF;    r0_address = R0_ADDR; r0_data = 32'hCAFEF00D;
        r1_byte_en = 4'b0011; r1_address = R1_ADDR; r1_data = 32'h12345678;
        setIn(0, 0, 0, 0, 0, 0, 32'h0);

        // Single read, then a continuous tie with memory_valid held high so that
        // it is also asserted outside WAIT, then a read+write request from r0
        vecs.push_back(mkVec(1,0,0,0, 1,0,32'h0,        1,0,0,0, 0,0,20'h0,   32'h0,        32'h0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,32'h0,        0,0,0,0, 1,0,R0_ADDR, 32'h0,        32'h0));
        vecs.push_back(mkVec(0,0,0,0, 1,1,32'hDEADBEEF, 0,0,0,0, 0,0,20'h0,   32'h0,        32'h0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,32'h0,        0,0,1,0, 0,0,20'h0,   32'hDEADBEEF, 32'h0));
        vecs.push_back(mkVec(0,0,0,0, 1,0,32'h0,        0,0,0,0, 0,0,20'h0,   32'hDEADBEEF, 32'h0));
        vecs.push_back(mkVec(1,0,1,0, 1,1,32'h0,        0,1,0,0, 0,0,20'h0,   32'hDEADBEEF, 32'h0));
        vecs.push_back(mkVec(1,0,1,0, 1,1,32'h11111111, 0,0,0,0, 1,0,R1_ADDR, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mkVec(1,0,1,0, 1,1,32'h22222222, 0,0,0,0, 0,0,20'h0,   32'hDEADBEEF, 32'h0));
        vecs.push_back(mkVec(1,0,1,0, 1,1,32'h0,        1,0,0,1, 0,0,20'h0,   32'hDEADBEEF, 32'h22222222));
        vecs.push_back(mkVec(1,0,1,0, 1,1,32'h33333333, 0,0,0,0, 1,0,R0_ADDR, 32'hDEADBEEF, 32'h22222222));
        vecs.push_back(mkVec(1,0,1,0, 1,1,32'h44444444, 0,0,0,0, 0,0,20'h0,   32'hDEADBEEF, 32'h22222222));
        vecs.push_back(mkVec(1,0,1,0, 1,1,32'h0,        0,1,1,0, 0,0,20'h0,   32'h44444444, 32'h22222222));
        vecs.push_back(mkVec(1,0,1,0, 1,1,32'h55555555, 0,0,0,0, 1,0,R1_ADDR, 32'h44444444, 32'h22222222));
        vecs.push_back(mkVec(1,0,1,0, 1,1,32'h66666666, 0,0,0,0, 0,0,20'h0,   32'h44444444, 32'h22222222));
        vecs.push_back(mkVec(1,0,1,0, 1,1,32'h0,        1,0,0,1, 0,0,20'h0,   32'h44444444, 32'h66666666));
        vecs.push_back(mkVec(0,0,0,0, 1,0,32'h0,        0,0,0,0, 1,0,R0_ADDR, 32'h44444444, 32'h66666666));
        vecs.push_back(mkVec(0,0,0,0, 1,1,32'h77777777, 0,0,0,0, 0,0,20'h0,   32'h44444444, 32'h66666666));
        vecs.push_back(mkVec(0,0,0,0, 1,0,32'h0,        0,0,1,0, 0,0,20'h0,   32'h77777777, 32'h66666666));
        vecs.push_back(mkVec(1,1,0,0, 1,0,32'h0,        1,0,0,0, 0,0,20'h0,   32'h77777777, 32'h66666666));
        vecs.push_back(mkVec(0,0,0,0, 1,0,32'h0,        0,0,0,0, 0,1,R0_ADDR, 32'h77777777, 32'h66666666));
        vecs.push_back(mkVec(0,0,0,0, 1,1,32'h99999999, 0,0,0,0, 0,0,20'h0,   32'h77777777, 32'h66666666));
        vecs.push_back(mkVec(0,0,0,0, 1,0,32'h0,        0,0,1,0, 0,0,20'h0,   32'h0,        32'h66666666));

        // Reset state
        repeat (3) @(posedge clock);
        sampleEdge;
        checkOutput("reset r0_valid", 32'(r0_valid), 32'h0);
        checkOutput("reset memory_read", 32'(memory_read), 32'h0);
        checkOutput("reset timeout_error", 32'(timeout_error), 32'h0);
        checkOutput("reset r0_rdata", r0_rdata, 32'h0);
        nextCycle;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            nextCycle;
            applyStimulus(vecs[i]);
            sampleEdge;
            checkOutput($sformatf("vec%0d r0_ready", i), 32'(r0_ready), 32'(vecs[i].eR0rdy));
            checkOutput($sformatf("vec%0d r1_ready", i), 32'(r1_ready), 32'(vecs[i].eR1rdy));
            checkOutput($sformatf("vec%0d r0_valid", i), 32'(r0_valid), 32'(vecs[i].eR0v));
            checkOutput($sformatf("vec%0d r1_valid", i), 32'(r1_valid), 32'(vecs[i].eR1v));
            checkOutput($sformatf("vec%0d memory_read", i), 32'(memory_read), 32'(vecs[i].eMrd));
            checkOutput($sformatf("vec%0d memory_write", i), 32'(memory_write), 32'(vecs[i].eMwr));
            checkOutput($sformatf("vec%0d memory_address", i), 32'(memory_address), 32'(vecs[i].eAddr));
            checkOutput($sformatf("vec%0d r0_rdata", i), r0_rdata, vecs[i].eRd0);
            checkOutput($sformatf("vec%0d r1_rdata", i), r1_rdata, vecs[i].eRd1);
            checkOutput($sformatf("vec%0d timeout_error", i), 32'(timeout_error), 32'h0);
        end

        // Backpressure: r1 write held off for 5 cycles, command must stay stable
        nextCycle; setIn(0,0,0,1, 0,0,32'h0); sampleEdge;
        checkOutput("bp r1_ready", 32'(r1_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            nextCycle; setIn(0,0,0,0, 0,0,32'h0); sampleEdge;
            checkOutput($sformatf("bp%0d memory_write", i), 32'(memory_write), 32'h1);
            checkOutput($sformatf("bp%0d memory_read", i), 32'(memory_read), 32'h0);
            checkOutput($sformatf("bp%0d memory_byte_en", i), 32'(memory_byte_en), 32'h3);
            checkOutput($sformatf("bp%0d memory_data", i), memory_data, 32'h12345678);
            checkOutput($sformatf("bp%0d memory_address", i), 32'(memory_address), 32'(R1_ADDR));
        end
        nextCycle; setIn(0,0,0,0, 1,0,32'h0); sampleEdge;
        checkOutput("bp accept memory_write", 32'(memory_write), 32'h1);
        nextCycle; setIn(0,0,0,0, 0,1,32'hBBBBBBBB); sampleEdge;
        checkOutput("bp wait memory_write", 32'(memory_write), 32'h0);
        checkOutput("bp wait r1_valid", 32'(r1_valid), 32'h0);
        nextCycle; setIn(0,0,0,0, 0,0,32'h0); sampleEdge;
        checkOutput("bp r1_valid", 32'(r1_valid), 32'h1);
        checkOutput("bp r1_rdata", r1_rdata, 32'h0);
        checkOutput("bp r0_valid", 32'(r0_valid), 32'h0);

        // Timeout: memory never answers; abort lands 8 cycles after the grant
        nextCycle; setIn(1,0,0,0, 1,0,32'h0); sampleEdge;
        checkOutput("to r0_ready", 32'(r0_ready), 32'h1);
        for (int k = 1; k < 8; k++) begin
            nextCycle; setIn(0,0,0,0, 1,0,32'h0); sampleEdge;
            checkOutput($sformatf("to t+%0d r0_valid", k), 32'(r0_valid), 32'h0);
            checkOutput($sformatf("to t+%0d timeout_error", k), 32'(timeout_error), 32'h0);
        end
        nextCycle; sampleEdge;
        checkOutput("to r0_valid", 32'(r0_valid), 32'h1);
        checkOutput("to r0_rdata", r0_rdata, 32'hFFFFFFFF);
        checkOutput("to timeout_error", 32'(timeout_error), 32'h1);
        nextCycle; setIn(1,0,0,0, 1,0,32'h0); sampleEdge;
        checkOutput("post-to r0_ready", 32'(r0_ready), 32'h1);
        nextCycle; setIn(0,0,0,0, 1,0,32'h0); sampleEdge;
        nextCycle; setIn(0,0,0,0, 1,1,32'hA5A5A5A5); sampleEdge;
        nextCycle; setIn(0,0,0,0, 0,0,32'h0); sampleEdge;
        checkOutput("post-to r0_valid", 32'(r0_valid), 32'h1);
        checkOutput("post-to r0_rdata", r0_rdata, 32'hA5A5A5A5);
        checkOutput("post-to timeout_error sticky", 32'(timeout_error), 32'h1);

        // Reset during WAIT aborts silently; a late memory_valid is ignored
        nextCycle; setIn(0,0,1,0, 1,0,32'h0); sampleEdge;
        checkOutput("rst r1_ready", 32'(r1_ready), 32'h1);
        nextCycle; setIn(0,0,0,0, 1,0,32'h0); sampleEdge;
        checkOutput("rst issue memory_read", 32'(memory_read), 32'h1);
        nextCycle; setIn(0,0,0,0, 0,0,32'h0); reset = 1'b0; sampleEdge;
        checkOutput("rst timeout_error", 32'(timeout_error), 32'h0);
        checkOutput("rst r0_rdata", r0_rdata, 32'h0);
        nextCycle; reset = 1'b1; setIn(0,0,0,0, 1,1,32'h00000012); sampleEdge;
        checkOutput("rst late r1_valid", 32'(r1_valid), 32'h0);
        checkOutput("rst late memory_read", 32'(memory_read), 32'h0);
        nextCycle; setIn(0,0,0,0, 0,0,32'h0); sampleEdge;
        checkOutput("rst after r1_valid", 32'(r1_valid), 32'h0);
        checkOutput("rst after r1_rdata", r1_rdata, 32'h0);
        checkOutput("rst after memory_address", 32'(memory_address), 32'h0);
        nextCycle; setIn(1,0,1,0, 1,0,32'h0); sampleEdge;
        checkOutput("rst tie r0_ready", 32'(r0_ready), 32'h1);
        checkOutput("rst tie r1_ready", 32'(r1_ready), 32'h0);
        nextCycle; setIn(0,0,0,0, 0,0,32'h0); sampleEdge;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
